wb_uart_rx_ctrl: RTL and testbench
==================================

// Module: wb_uart_rx_ctrl
// PURPOSE
// Receive-side controller for the UART RX byte engine. Acts as Wishbone master to the
// RX engine: drains every completed byte into a DEPTH-entry FIFO. Flags overrun when a
// byte arrives with the FIFO full. Acts as Wishbone B4 slave to the CPU, exposing
// DATA, STATUS, CTRL and LEVEL registers, and drives a level interrupt.
// PARAMETERS
// DEPTH  8  FIFO entries; power of two, 2..128. CW = $clog2(DEPTH)+1 count bits.
// PORTS
// i_wb_clk     in   1   clock
// i_wb_rst     in   1   synchronous reset, active high
// i_wb_stb     in   1   CPU request strobe
// i_wb_we      in   1   CPU write enable
// i_wb_adr     in   2   register select: 0 DATA, 1 STATUS, 2 CTRL, 3 LEVEL
// i_wb_data    in   8   CPU write data
// o_wb_data    out  8   CPU read data, valid with o_wb_ack
// o_wb_ack     out  1   CPU ack, registered
// o_wb_stall   out  1   tied 0
// o_rx_stb     out  1   strobe to RX engine
// i_rx_data    in   8   RX engine byte
// i_rx_ack     in   1   RX engine ack; byte on i_rx_data is valid this cycle
// o_irq        out  1   interrupt, registered level
// BEHAVIOUR
// Reset: FIFO empty, count 0, overrun 0, rx_en 1, irq_en 0, threshold 1.
//   Outputs after reset: o_wb_ack 0, o_wb_data 0x00, o_irq 0.
// Reset mid-transfer drops all FIFO contents and any in-flight CPU ack.
// RX side: o_rx_stb = rx_en (combinational).
//   On i_rx_ack with count<DEPTH: push i_rx_data.
//   On i_rx_ack with count==DEPTH and no pop this cycle: drop byte; set overrun.
//   Push and pop in the same cycle at full: both happen; no overrun.
//   Push and pop in the same cycle at empty: pop returns 0x00; push lands.
// CPU side: accept every cycle (no stall). o_wb_ack=1 exactly one cycle after i_wb_stb.
//   o_wb_data is registered with the ack; it is 0x00 for writes.
// Register reads:
//   DATA read: returns FIFO head and pops it; if empty returns 0x00, no pop.
//   STATUS read: {5'b0, overrun, full, !empty}.
//   CTRL read: {6'b0, irq_en, rx_en}.
//   LEVEL read: count, zero-extended to 8 bits.
// Register writes:
//   DATA write: ignored.
//   STATUS write: bit2=1 clears overrun (W1C). A new overrun in the same cycle wins.
//   CTRL write: bit0 rx_en; bit1 irq_en. bit7=1 flushes FIFO: count 0, pointers 0.
//     The flush beats any push in the same cycle. bit7 reads 0.
//   LEVEL write: threshold=i_wb_data[CW-1:0]. Value 0 stored as 1. Values >DEPTH saturate to DEPTH.
// FIFO: read/write pointers of CW-1 bits, wrapping modulo DEPTH. count is 0..DEPTH.
//   full = count==DEPTH; empty = count==0.
// o_irq: next = irq_en & ((count_next >= threshold) | overrun_next).
//   Registered, so it follows the causing event by one cycle.
// Popped data reflects the head before any same-cycle push (read-before-write).
// TESTING
// Reset, then read STATUS -> 0x00. Read CTRL -> 0x01. Read LEVEL -> 0x00. o_irq=0.
// Push 0x55, 0xA3 via i_rx_ack. Read DATA twice -> 0x55 then 0xA3. Read STATUS -> 0x00.
// Push 9 bytes 0x01..0x09 (DEPTH 8). STATUS -> 0x07 (full+overrun+valid).
//   Draining 8 DATA reads yields 0x01..0x08. Write STATUS 0x04 -> STATUS 0x00.
// Write CTRL 0x02, LEVEL 3. Push 2 bytes -> o_irq=0. Push third -> o_irq=1 next cycle.
//   One DATA read -> o_irq=0 the cycle after.
// Fill FIFO; assert i_rx_ack together with a DATA pop -> no overrun; LEVEL stays 8.
// Write CTRL 0x81 while i_rx_ack pulses -> LEVEL 0. Write CTRL 0x00 -> o_rx_stb=0.
//   Assert i_wb_rst mid-stream -> o_wb_ack 0 and LEVEL 0 on the next read.

Source files
------------

// File: rtl/wb_uart_rx_ctrl.sv
// UART receive-side controller: drains bytes from the RX engine into a FIFO and
// exposes DATA/STATUS/CTRL/LEVEL registers plus a level interrupt to the CPU.
module wb_uart_rx_ctrl #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic       i_wb_clk,
  input  logic       i_wb_rst,
  input  logic       i_wb_stb,
  input  logic       i_wb_we,
  input  logic [1:0] i_wb_adr,
  input  logic [7:0] i_wb_data,
  output logic [7:0] o_wb_data,
  output logic       o_wb_ack,
  output logic       o_wb_stall,
  output logic       o_rx_stb,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_ack,
  output logic       o_irq
);
  localparam int PW = CW - 1;
  localparam logic [1:0] A_DATA = 2'd0, A_STAT = 2'd1, A_CTRL = 2'd2, A_LVL = 2'd3;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt, thr, thr_nxt, thr_in;
  logic          overrun, overrun_nxt, rx_en, irq_en, irq_en_nxt;
  logic          full, empty, rd, wr, pop, push, flush, ovr_set, ovr_clr;
  logic [7:0]    rd_data;

  assign o_wb_stall = 1'b0;
  assign o_rx_stb   = rx_en;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign rd      = i_wb_stb & ~i_wb_we;
  assign wr      = i_wb_stb &  i_wb_we;
  assign pop     = rd & (i_wb_adr == A_DATA) & ~empty;
  assign flush   = wr & (i_wb_adr == A_CTRL) & i_wb_data[7];
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign push    = i_rx_ack & (~full | pop) & ~flush;
  assign ovr_set = i_rx_ack & full & ~pop;
  assign ovr_clr = wr & (i_wb_adr == A_STAT) & i_wb_data[2];
  assign thr_in  = i_wb_data[CW-1:0];

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (push & ~pop)
      count_nxt = count + 1'b1;
    else if (pop & ~push)
      count_nxt = count - 1'b1;
  end

  assign overrun_nxt = ovr_set | (overrun & ~ovr_clr);
  assign irq_en_nxt  = (wr & (i_wb_adr == A_CTRL)) ? i_wb_data[1] : irq_en;

  always_comb begin
    thr_nxt = thr;
    if (wr & (i_wb_adr == A_LVL)) begin
      if (thr_in == '0)         thr_nxt = CW'(1);
      else if (thr_in > DEPTH_C) thr_nxt = DEPTH_C;
      else                      thr_nxt = thr_in;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (i_wb_adr)
      A_DATA: rd_data = empty ? 8'h00 : mem[rd_ptr];
      A_STAT: rd_data = {5'b0, overrun, full, ~empty};
      A_CTRL: rd_data = {6'b0, irq_en, rx_en};
      A_LVL:  rd_data = 8'(count);
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge i_wb_clk)
    if (push) mem[wr_ptr] <= i_rx_data;

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      rx_en     <= 1'b1;
      irq_en    <= 1'b0;
      thr       <= CW'(1);
      o_wb_ack  <= 1'b0;
      o_wb_data <= 8'h00;
      o_irq     <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      count   <= count_nxt;
      overrun <= overrun_nxt;
      thr     <= thr_nxt;
      irq_en  <= irq_en_nxt;
      if (wr & (i_wb_adr == A_CTRL)) rx_en <= i_wb_data[0];
      o_wb_ack  <= i_wb_stb;
      o_wb_data <= rd ? rd_data : 8'h00;
      o_irq     <= irq_en_nxt & ((count_nxt >= thr_nxt) | overrun_nxt);
    end
  end
endmodule

// File: tb/tb_wb_uart_rx_ctrl.sv
// Directed bench for wb_uart_rx_ctrl: expected read data queued at issue time,
// checked by an independent monitor when the ack shows up.
module tb_wb_uart_rx_ctrl;
  logic       clk = 1'b0, rst = 1'b1;
  logic       stb = 1'b0, we = 1'b0, rx_ack = 1'b0;
  logic [1:0] adr = '0;
  logic [7:0] wdat = '0, rx_data = '0;
  logic [7:0] rdat;
  logic       ack, stall, rx_stb, irq;

  int total = 0, bad = 0;
  logic [7:0] expq [$];
  string      nameq [$];

  wb_uart_rx_ctrl #(.DEPTH(8)) dut (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_adr(adr), .i_wb_data(wdat), .o_wb_data(rdat), .o_wb_ack(ack),
    .o_wb_stall(stall), .o_rx_stb(rx_stb), .i_rx_data(rx_data),
    .i_rx_ack(rx_ack), .o_irq(irq)
  );

  always #5 clk = ~clk;

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ack) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack: got ack data=%02h, required no ack", rdat);
      end else begin
        automatic logic [7:0] e = expq.pop_front();
        automatic string n = nameq.pop_front();
        if (rdat !== e) begin
          bad++;
          $display("FAIL %s: got %02h, required %02h", n, rdat, e);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h, required %02h", n, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0; rx_ack = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e, input string n);
    stb = 1'b1; we = 1'b0; adr = a;
    expq.push_back(e); nameq.push_back(n);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    stb = 1'b1; we = 1'b1; adr = a; wdat = d;
    expq.push_back(8'h00); nameq.push_back("write_data");
  endtask

  task automatic rx(input logic [7:0] d);
    rx_ack = 1'b1; rx_data = d;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {7'b0, ack}, 8'h00);
    chk("rst_data", rdat, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    rst = 1'b0;

    rd(1, 8'h00, "rst_status"); tick();
    rd(2, 8'h01, "rst_ctrl");   tick();
    rd(3, 8'h00, "rst_level");  tick();
    chk("rst_rx_stb", {7'b0, rx_stb}, 8'h01);

    rx(8'h55); tick(); rx(8'hA3); tick();
    rd(0, 8'h55, "data0"); tick();
    rd(0, 8'hA3, "data1"); tick();
    rd(1, 8'h00, "status_empty"); tick();

    for (int i = 1; i <= 9; i++) begin rx(8'(i)); tick(); end
    rd(1, 8'h07, "status_ovr_full"); tick();
    rd(3, 8'h08, "level_full"); tick();
    for (int i = 1; i <= 8; i++) begin rd(0, 8'(i), "drain"); tick(); end
    rd(1, 8'h04, "status_ovr_only"); tick();
    wr(1, 8'h04); tick();
    rd(1, 8'h00, "status_w1c"); tick();

    wr(2, 8'h02); tick();
    wr(3, 8'h03); tick();
    rx(8'hAA); tick(); rx(8'hBB); tick();
    chk("irq_below_thr", {7'b0, irq}, 8'h00);
    rx(8'hCC); tick();
    chk("irq_at_thr", {7'b0, irq}, 8'h01);
    rd(0, 8'hAA, "data_irq"); tick();
    chk("irq_after_pop", {7'b0, irq}, 8'h00);

    for (int i = 0; i < 6; i++) begin rx(8'h10 + 8'(i)); tick(); end
    rd(3, 8'h08, "level_refill"); tick();
    rd(0, 8'hBB, "pop_push_full"); rx(8'h16); tick();
    rd(3, 8'h08, "level_pop_push"); tick();
    rd(1, 8'h03, "status_no_ovr"); tick();
    wr(1, 8'h04); rx(8'h17); tick();
    rd(1, 8'h07, "status_ovr_wins"); tick();
    chk("irq_full", {7'b0, irq}, 8'h01);

    wr(2, 8'h81); rx(8'h77); tick();
    rd(3, 8'h00, "level_flush"); tick();
    rd(2, 8'h01, "ctrl_bit7"); tick();
    chk("irq_off", {7'b0, irq}, 8'h00);
    wr(1, 8'h04); tick();
    wr(2, 8'h00); tick();
    chk("rx_stb_off", {7'b0, rx_stb}, 8'h00);

    rd(0, 8'h00, "pop_empty_push"); rx(8'h42); tick();
    rd(3, 8'h01, "level_one"); tick();
    rd(0, 8'h42, "data_late"); tick();

    wr(2, 8'h82); tick();
    wr(3, 8'h00); tick();
    chk("irq_thr0_empty", {7'b0, irq}, 8'h00);
    rx(8'h01); tick();
    chk("irq_thr0_as_1", {7'b0, irq}, 8'h01);
    wr(2, 8'h82); tick();
    wr(3, 8'hFF); tick();
    for (int i = 0; i < 7; i++) begin rx(8'(i)); tick(); end
    chk("irq_sat_7", {7'b0, irq}, 8'h00);
    rx(8'h07); tick();
    chk("irq_sat_8", {7'b0, irq}, 8'h01);

    rx(8'h99); tick();
    rst = 1'b1; rd(1, 8'h00, "unused"); tick();
    void'(expq.pop_back()); void'(nameq.pop_back());
    chk("rst_drop_ack", {7'b0, ack}, 8'h00);
    tick();
    rst = 1'b0;
    rd(3, 8'h00, "level_after_rst"); tick();
    rd(2, 8'h01, "ctrl_after_rst"); tick();
    repeat (3) @(posedge clk);
    #1;
    chk("pending_acks", 8'(expq.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
